// File: rtl/vga_pkg.sv
// Shared geometry, colour width and FSM encoding for the rectangle fill engine.
package vga_pkg;
    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int COLOR_BITS = 15;
    localparam int X_BITS     = 8;
    localparam int Y_BITS     = 7;

    typedef logic [X_BITS-1:0]     x_t;
    typedef logic [Y_BITS-1:0]     y_t;
    typedef logic [COLOR_BITS-1:0] color_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/vga_rect_filler_if.sv
// Request handshake plus pixel bus of the fill engine; master = requester, slave = engine.
interface vga_rect_filler_if;
    import vga_pkg::*;

    logic   start;
    logic   abort;
    x_t     x0;
    y_t     y0;
    x_t     width;
    y_t     height;
    color_t color;
    logic   ready;
    logic   busy;
    logic   done;
    x_t     vga_x;
    y_t     vga_y;
    color_t vga_color;
    logic   vga_plot;

    modport master (
        output start, abort, x0, y0, width, height, color,
        input  ready, busy, done, vga_x, vga_y, vga_color, vga_plot
    );

    modport slave (
        input  start, abort, x0, y0, width, height, color,
        output ready, busy, done, vga_x, vga_y, vga_color, vga_plot
    );
endinterface

// File: rtl/rect_clip.sv
// Combinational clip of a requested rectangle to the framebuffer: last column/row plus empty flag.
// Sums are one bit wider than the coordinates so x0+width cannot wrap before the min().
module rect_clip
    import vga_pkg::*;
#(
    parameter int SW = SCREEN_W,
    parameter int SH = SCREEN_H
) (
    input  x_t   x0,
    input  y_t   y0,
    input  x_t   width,
    input  y_t   height,
    output x_t   x_last,
    output y_t   y_last,
    output logic empty
);
    logic [X_BITS:0] x_end;
    logic [X_BITS:0] x_lim;
    logic [Y_BITS:0] y_end;
    logic [Y_BITS:0] y_lim;

    always_comb begin
        x_end  = {1'b0, x0} + {1'b0, width};
        y_end  = {1'b0, y0} + {1'b0, height};
        x_lim  = (x_end > (X_BITS+1)'(SW)) ? (X_BITS+1)'(SW) : x_end;
        y_lim  = (y_end > (Y_BITS+1)'(SH)) ? (Y_BITS+1)'(SH) : y_end;
        x_last = X_BITS'(x_lim - (X_BITS+1)'(1));
        y_last = Y_BITS'(y_lim - (Y_BITS+1)'(1));
        empty  = (width == '0) || (height == '0) ||
                 (x0 >= X_BITS'(SW)) || (y0 >= Y_BITS'(SH));
    end
endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: one plot per clock in raster order; first pixel the cycle after acceptance.
// No backpressure toward the adapter; start is only taken in IDLE and never queued.
module vga_rect_filler
    import vga_pkg::*;
#(
    parameter int SCREEN_W_P = SCREEN_W,
    parameter int SCREEN_H_P = SCREEN_H
) (
    input  logic              clock,
    input  logic              resetn,
    vga_rect_filler_if.slave  bus
);
    state_t state, state_nxt;
    x_t     x_org, x_lim;
    y_t     y_lim;
    x_t     pix_x;
    y_t     pix_y;
    color_t pix_color;
    logic   pix_plot;

    x_t     clip_xl;
    y_t     clip_yl;
    logic   clip_empty;
    logic   accept;
    logic   last_px;

    rect_clip #(.SW(SCREEN_W_P), .SH(SCREEN_H_P)) u_clip (
        .x0     (bus.x0),
        .y0     (bus.y0),
        .width  (bus.width),
        .height (bus.height),
        .x_last (clip_xl),
        .y_last (clip_yl),
        .empty  (clip_empty)
    );

    assign accept  = (state == ST_IDLE) && bus.start;
    assign last_px = (pix_x >= x_lim) && (pix_y >= y_lim);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = clip_empty ? ST_DONE : ST_FILL;
            ST_FILL: if (bus.abort || last_px) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // The bounds are latched with the request so inputs may change freely during a fill.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_org     <= '0;
            x_lim     <= '0;
            y_lim     <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            pix_plot  <= 1'b0;
        end else if (accept && !clip_empty) begin
            x_org     <= bus.x0;
            x_lim     <= clip_xl;
            y_lim     <= clip_yl;
            pix_x     <= bus.x0;
            pix_y     <= bus.y0;
            pix_color <= bus.color;
            pix_plot  <= 1'b1;
        end else if (state == ST_FILL) begin
            if (bus.abort || last_px) begin
                pix_plot <= 1'b0;
            end else if (pix_x < x_lim) begin
                pix_x <= pix_x + x_t'(1);
            end else begin
                pix_x <= x_org;
                pix_y <= pix_y + y_t'(1);
            end
        end
    end

    assign bus.ready     = (state == ST_IDLE);
    assign bus.busy      = (state == ST_FILL);
    assign bus.done      = (state == ST_DONE);
    assign bus.vga_x     = pix_x;
    assign bus.vga_y     = pix_y;
    assign bus.vga_color = pix_color;
    assign bus.vga_plot  = pix_plot;
endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed bench for vga_rect_filler: raster order, clipping, empty requests, abort, ignored restart, reset.
module tb_vga_rect_filler;
    logic CLOCK_50 = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   n, lx, ly;

    always #5 CLOCK_50 = ~CLOCK_50;

    vga_rect_filler_if bus ();

    vga_rect_filler dut (
        .clock  (CLOCK_50),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic issue(input int x0, input int y0, input int w, input int h, input logic [14:0] c);
        bus.x0     = 8'(x0);
        bus.y0     = 7'(y0);
        bus.width  = 8'(w);
        bus.height = 7'(h);
        bus.color  = c;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    // Walks the plot burst against a raster model of the clipped rectangle, then checks the done pulse.
    task automatic collect(input int ex0, input int ey0, input int exl, input logic [14:0] ecol,
                           input bit per_pixel, input int abort_at, input bit restart,
                           input int max_cyc, output int cnt, output int last_x, output int last_y);
        int mx, my;
        mx = ex0; my = ey0; cnt = 0; last_x = -1; last_y = -1;
        for (int c = 0; c < max_cyc && bus.vga_plot; c++) begin
            cnt++;
            if (per_pixel) begin
                chk("pix_x", bus.vga_x, mx);
                chk("pix_y", bus.vga_y, my);
                chk("pix_color", bus.vga_color, ecol);
                chk("pix_busy", bus.busy, 1);
            end
            last_x = bus.vga_x;
            last_y = bus.vga_y;
            if (mx < exl) mx++;
            else begin mx = ex0; my++; end
            if (cnt == abort_at) bus.abort = 1'b1;
            if (restart && cnt == 3) begin
                bus.start = 1'b1; bus.color = 15'h001F; bus.x0 = 8'd50; bus.y0 = 7'd50;
                bus.width = 8'd2; bus.height = 7'd2;
            end
            tick();
            bus.abort = 1'b0;
            bus.start = 1'b0;
        end
        chk("burst_ended", bus.vga_plot, 0);
        chk("done_pulse", bus.done, 1);
        chk("busy_after", bus.busy, 0);
        tick();
        chk("done_once", bus.done, 0);
        chk("ready_back", bus.ready, 1);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.width = '0; bus.height = '0; bus.color = '0;
        resetn = 1'b0;
        #2;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_plot", bus.vga_plot, 0);
        chk("rst_x", bus.vga_x, 0);
        chk("rst_y", bus.vga_y, 0);
        chk("rst_color", bus.vga_color, 0);
        tick();
        resetn = 1'b1;
        tick();

        // 3x2 block: six pixels in raster order
        issue(10, 20, 3, 2, 15'h7FFF);
        collect(10, 20, 12, 15'h7FFF, 1, 0, 0, 20, n, lx, ly);
        chk("t1_count", n, 6);
        chk("t1_last_x", lx, 12);
        chk("t1_last_y", ly, 21);
        chk("t1_color_hold", bus.vga_color, 15'h7FFF);

        // bottom-right corner clip
        issue(158, 119, 5, 5, 15'h0123);
        collect(158, 119, 159, 15'h0123, 1, 0, 0, 20, n, lx, ly);
        chk("t2_count", n, 2);
        chk("t2_last_x", lx, 159);

        // empty requests: zero width, off-screen column, zero height
        issue(160, 0, 0, 5, 15'h0AAA);
        chk("t3a_plot", bus.vga_plot, 0);
        chk("t3a_done", bus.done, 1);
        tick();
        chk("t3a_ready", bus.ready, 1);
        chk("t3a_done_clr", bus.done, 0);
        issue(160, 0, 5, 5, 15'h0AAA);
        chk("t3b_plot", bus.vga_plot, 0);
        chk("t3b_done", bus.done, 1);
        tick();
        issue(5, 5, 5, 0, 15'h0AAA);
        chk("t3c_plot", bus.vga_plot, 0);
        chk("t3c_done", bus.done, 1);
        tick();
        chk("t3c_ready", bus.ready, 1);

        // start during fill is dropped; original colour throughout
        issue(20, 30, 4, 4, 15'h5555);
        collect(20, 30, 23, 15'h5555, 1, 0, 1, 40, n, lx, ly);
        chk("t4_count", n, 16);
        chk("t4_last_y", ly, 33);
        tick();
        chk("t4_not_queued", bus.vga_plot, 0);
        chk("t4_still_idle", bus.ready, 1);

        // abort on the 6th plot cycle
        issue(20, 30, 4, 4, 15'h2222);
        collect(20, 30, 23, 15'h2222, 1, 6, 0, 40, n, lx, ly);
        chk("t5_count", n, 6);
        chk("t5_last_x", lx, 21);
        chk("t5_last_y", ly, 31);

        // asynchronous reset mid-fill
        issue(0, 0, 10, 10, 15'h3333);
        tick(); tick();
        chk("t6_plot_before", bus.vga_plot, 1);
        resetn = 1'b0;
        #1;
        chk("t6_plot_rst", bus.vga_plot, 0);
        chk("t6_ready_rst", bus.ready, 1);
        chk("t6_busy_rst", bus.busy, 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("t6_no_done", bus.done, 0);
        chk("t6_idle", bus.ready, 1);
        issue(5, 5, 2, 1, 15'h1234);
        collect(5, 5, 6, 15'h1234, 1, 0, 0, 20, n, lx, ly);
        chk("t6_next_count", n, 2);

        // full-screen fill clipped from 200x127
        issue(0, 0, 200, 127, 15'h4321);
        collect(0, 0, 159, 15'h4321, 0, 0, 0, 20000, n, lx, ly);
        chk("t7_count", n, 19200);
        chk("t7_last_x", lx, 159);
        chk("t7_last_y", ly, 119);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
